term_bus_connect_sequencer: RTL and testbench

- Controls which bits of an output term bus are driven from an internal net bus, and which bits are erased (held at 0).
- Holds a per-bit connection mask and accepts connect/erase commands over a valid/ready interface.
- Range commands are applied one bit per cycle by a sweep FSM.
- Sits between a configuration source and the output term bus; used to model partially connected top-level buses in generated netlists.

---
 rtl/term_bus_connect_sequencer.sv | 107 ++++++++++
 tb/tb_term_bus_connect_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/term_bus_connect_sequencer.sv
// Per-bit connection mask between an internal net bus and an output term bus.
// Connect/erase commands arrive over valid/ready; range commands sweep one bit per cycle.
module term_bus_connect_sequencer #(
   parameter  int               WIDTH      = 32,
   parameter  logic [WIDTH-1:0] RESET_MASK = {WIDTH{1'b1}},
   localparam int               IDXW       = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] net_in,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [IDXW-1:0]  cmd_lo,
   input  logic [IDXW-1:0]  cmd_hi,
   output logic [WIDTH-1:0] term_out,
   output logic [WIDTH-1:0] conn_mask,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [1:0]       dbg_state
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SWEEP = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [1:0] OP_CONNECT_RANGE = 2'd0;
   localparam logic [1:0] OP_CONNECT_ALL   = 2'd2;
   localparam logic [1:0] OP_ERASE_ALL     = 2'd3;

   localparam logic [IDXW:0] LAST_IDX = (IDXW+1)'(WIDTH-1);

   logic [1:0]       r_state;
   logic [IDXW-1:0]  r_cursor;
   logic [IDXW-1:0]  r_hi;
   logic             r_val;
   logic             r_err_pending;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] r_term;

   logic             w_accept;
   logic             w_reject;

   // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
   // cmd_ready is high only in IDLE and out of reset, and cmd_* are sampled only then.
   assign cmd_ready = rst_n & (r_state == S_IDLE);
   assign w_accept  = cmd_valid & cmd_ready;
   assign w_reject  = (cmd_lo > cmd_hi) || ({1'b0, cmd_hi} > LAST_IDX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_cursor      <= '0;
         r_hi          <= '0;
         r_val         <= 1'b0;
         r_err_pending <= 1'b0;
         r_mask        <= RESET_MASK;
         r_term        <= '0;
      end else begin
         r_term <= net_in & r_mask;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (cmd_op == OP_CONNECT_ALL) begin
                     r_mask  <= '1;
                     r_state <= S_DONE;
                  end else if (cmd_op == OP_ERASE_ALL) begin
                     r_mask  <= '0;
                     r_state <= S_DONE;
                  end else if (w_reject) begin
                     r_err_pending <= 1'b1;
                     r_state       <= S_DONE;
                  end else begin
                     r_cursor <= cmd_lo;
                     r_hi     <= cmd_hi;
                     r_val    <= (cmd_op == OP_CONNECT_RANGE);
                     r_state  <= S_SWEEP;
                  end
               end
            end
            // hi was range-checked at acceptance, so the cursor never runs past WIDTH-1.
            S_SWEEP: begin
               r_mask[r_cursor] <= r_val;
               if (r_cursor == r_hi) begin
                  r_state <= S_DONE;
               end else begin
                  r_cursor <= r_cursor + IDXW'(1);
               end
            end
            S_DONE: begin
               r_err_pending <= 1'b0;
               r_state       <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);
   assign err       = done & r_err_pending;
   assign conn_mask = r_mask;
   assign term_out  = r_term;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_term_bus_connect_sequencer.sv
// Bench for term_bus_connect_sequencer: directed scenarios plus random commands
// checked against a bit-range model of the connection mask.
module tb_term_bus_connect_sequencer;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  net_in = '0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = '0;
   logic [4:0]    cmd_lo = '0;
   logic [4:0]    cmd_hi = '0;
   logic [W-1:0]  term_out;
   logic [W-1:0]  conn_mask;
   logic          busy;
   logic          done;
   logic          err;
   logic [1:0]    dbg_state;

   int            n_vec = 0;
   int            n_err = 0;
   logic [W-1:0]  m_mask;

   term_bus_connect_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .net_in(net_in),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_lo(cmd_lo), .cmd_hi(cmd_hi), .term_out(term_out),
      .conn_mask(conn_mask), .busy(busy), .done(done), .err(err),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present one command for a single edge, then scramble cmd_* to show they are not resampled.
   task automatic issue(input int op, input int lo, input int hi);
      cmd_op    = 2'(op);
      cmd_lo    = 5'(lo);
      cmd_hi    = 5'(hi);
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom_range(3, 0));
      cmd_lo    = 5'($urandom_range(31, 0));
      cmd_hi    = 5'($urandom_range(31, 0));
   endtask

   function automatic bit is_rejected(input int op, input int lo, input int hi);
      return (op < 2) && ((lo > hi) || (hi > W - 1));
   endfunction

   // Cycle k = 1 is the cycle right after the accept edge.
   function automatic int latency(input int op, input int lo, input int hi);
      if (op >= 2 || is_rejected(op, lo, hi)) return 1;
      return (hi - lo + 1) + 1;
   endfunction

   // Expected mask seen in cycle k: a range has written bits lo .. lo+k-2 so far.
   function automatic logic [W-1:0] exp_mask_at(input logic [W-1:0] base, input int op,
                                                input int lo, input int hi, input int k);
      logic [W-1:0] m;
      m = base;
      if (op == 2) return '1;
      if (op == 3) return '0;
      if (is_rejected(op, lo, hi)) return base;
      for (int i = lo; i <= hi && i <= lo + k - 2; i++) m[i] = (op == 0);
      return m;
   endfunction

   task automatic test_reset;
      rst_n  = 1'b0;
      net_in = 32'hA5A5_A5A5;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if (cmd_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: ready=%b done=%b err=%b, want 0 0 0", cmd_ready, done, err);
         end
      end
      n_vec++;
      if (conn_mask !== 32'hFFFF_FFFF || term_out !== 32'h0) begin
         n_err++;
         $display("FAIL reset_regs: mask=%h term=%h, want ffffffff 00000000", conn_mask, term_out);
      end
      rst_n = 1'b1;
      #1;
      n_vec++;
      if (cmd_ready !== 1'b1 || term_out !== 32'h0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL release_first_cycle: ready=%b term=%h busy=%b, want 1 00000000 0",
                  cmd_ready, term_out, busy);
      end
      tick();
      n_vec++;
      if (term_out !== 32'hA5A5_A5A5) begin
         n_err++;
         $display("FAIL release_term_out: got %h want a5a5a5a5", term_out);
      end
      m_mask = '1;
   endtask

   task automatic test_erase_single;
      int idx_list[4] = '{0, 15, 20, 31};
      net_in = 32'hFFFF_FFFF;
      foreach (idx_list[j]) begin
         issue(1, idx_list[j], idx_list[j]);
         n_vec++;
         if (done !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL erase_single_c1 bit=%0d: done=%b busy=%b, want 0 1", idx_list[j], done, busy);
         end
         tick();
         n_vec++;
         if (done !== 1'b1 || err !== 1'b0 || cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL erase_single_c2 bit=%0d: done=%b err=%b ready=%b, want 1 0 0",
                     idx_list[j], done, err, cmd_ready);
         end
         tick();
         m_mask[idx_list[j]] = 1'b0;
      end
      n_vec++;
      if (conn_mask !== 32'h7FEF_7FFE || conn_mask !== m_mask) begin
         n_err++;
         $display("FAIL erase_single_mask: got %h want 7fef7ffe", conn_mask);
      end
      n_vec++;
      if (term_out !== 32'h7FEF_7FFE || cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL erase_single_term: term=%h ready=%b, want 7fef7ffe 1", term_out, cmd_ready);
      end
   endtask

   task automatic test_erase_range;
      logic [W-1:0] exp;
      issue(2, 0, 0);
      n_vec++;
      if (done !== 1'b1 || conn_mask !== 32'hFFFF_FFFF) begin
         n_err++;
         $display("FAIL connect_all: done=%b mask=%h, want 1 ffffffff", done, conn_mask);
      end
      tick();
      issue(1, 4, 11);
      for (int k = 1; k <= 9; k++) begin
         exp = 32'hFFFF_FFFF & ~(32'(((64'd1 << (k - 1)) - 64'd1)) << 4);
         n_vec++;
         if (conn_mask !== exp || busy !== 1'b1 || done !== (k == 9)) begin
            n_err++;
            $display("FAIL erase_range cycle=%0d: mask=%h busy=%b done=%b, want %h 1 %b",
                     k, conn_mask, busy, done, exp, (k == 9));
         end
         tick();
      end
      n_vec++;
      if (conn_mask !== 32'hFFFF_F00F || busy !== 1'b0) begin
         n_err++;
         $display("FAIL erase_range_final: mask=%h busy=%b, want fffff00f 0", conn_mask, busy);
      end
   endtask

   task automatic test_erase_all_connect;
      int k;
      issue(3, 0, 0);
      n_vec++;
      if (conn_mask !== 32'h0 || done !== 1'b1) begin
         n_err++;
         $display("FAIL erase_all: mask=%h done=%b, want 00000000 1", conn_mask, done);
      end
      tick();
      issue(0, 0, 31);
      k = 1;
      while (done !== 1'b1 && k < 40) begin
         n_vec++;
         if (conn_mask !== 32'(((64'd1 << (k - 1)) - 64'd1))) begin
            n_err++;
            $display("FAIL connect_sweep cycle=%0d: mask=%h want %h",
                     k, conn_mask, 32'(((64'd1 << (k - 1)) - 64'd1)));
         end
         tick();
         k++;
      end
      n_vec++;
      if (k !== 33 || conn_mask !== 32'hFFFF_FFFF) begin
         n_err++;
         $display("FAIL connect_all_range: done_cycle=%0d mask=%h, want 33 ffffffff", k, conn_mask);
      end
      tick();
      m_mask = '1;
   endtask

   task automatic test_reject;
      cmd_op = 2'd0; cmd_lo = 5'd9; cmd_hi = 5'd3; cmd_valid = 1'b1;
      tick();
      n_vec++;
      if (done !== 1'b1 || err !== 1'b1 || conn_mask !== m_mask || cmd_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reject_lo_gt_hi: done=%b err=%b mask=%h ready=%b, want 1 1 %h 0",
                  done, err, conn_mask, cmd_ready, m_mask);
      end
      cmd_op = 2'd3;
      tick();
      cmd_valid = 1'b0;
      n_vec++;
      if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || conn_mask !== m_mask) begin
         n_err++;
         $display("FAIL valid_during_busy: done=%b err=%b busy=%b mask=%h, want 0 0 0 %h",
                  done, err, busy, conn_mask, m_mask);
      end
      tick();
      issue(1, 31, 0);
      n_vec++;
      if (done !== 1'b1 || err !== 1'b1 || conn_mask !== m_mask) begin
         n_err++;
         $display("FAIL reject_31_0: done=%b err=%b mask=%h, want 1 1 %h", done, err, conn_mask, m_mask);
      end
      tick();
   endtask

   task automatic test_reset_mid_sweep;
      int pulses = 0;
      issue(1, 0, 31);
      tick();
      tick();
      n_vec++;
      if (conn_mask !== 32'hFFFF_FFFC) begin
         n_err++;
         $display("FAIL mid_sweep_mask: got %h want fffffffc", conn_mask);
      end
      rst_n = 1'b0;
      tick();
      n_vec++;
      if (conn_mask !== 32'hFFFF_FFFF || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         n_err++;
         $display("FAIL abort_reset: mask=%h busy=%b done=%b err=%b, want ffffffff 0 0 0",
                  conn_mask, busy, done, err);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done === 1'b1 || err === 1'b1) pulses++;
      end
      n_vec++;
      if (pulses !== 0 || conn_mask !== 32'hFFFF_FFFF) begin
         n_err++;
         $display("FAIL aborted_no_done: pulses=%0d mask=%h, want 0 ffffffff", pulses, conn_mask);
      end
      m_mask = '1;
   endtask

   task automatic test_random;
      int op, lo, hi, lat;
      logic [W-1:0] exp;
      for (int n = 0; n < 40; n++) begin
         op     = $urandom_range(3, 0);
         lo     = $urandom_range(31, 0);
         hi     = $urandom_range(31, 0);
         net_in = $urandom;
         lat    = latency(op, lo, hi);
         issue(op, lo, hi);
         for (int k = 1; k <= lat; k++) begin
            exp = exp_mask_at(m_mask, op, lo, hi, k);
            n_vec++;
            if (conn_mask !== exp || busy !== 1'b1 || cmd_ready !== 1'b0 || done !== (k == lat) ||
                err !== (k == lat && is_rejected(op, lo, hi))) begin
               n_err++;
               $display("FAIL random n=%0d op=%0d lo=%0d hi=%0d k=%0d: mask=%h done=%b err=%b busy=%b, want %h %b %b 1",
                        n, op, lo, hi, k, conn_mask, done, err, busy, exp, (k == lat),
                        (k == lat && is_rejected(op, lo, hi)));
            end
            tick();
         end
         m_mask = exp_mask_at(m_mask, op, lo, hi, lat);
         n_vec++;
         if (busy !== 1'b0 || cmd_ready !== 1'b1 || conn_mask !== m_mask ||
             term_out !== (net_in & m_mask)) begin
            n_err++;
            $display("FAIL random_idle n=%0d: busy=%b ready=%b mask=%h term=%h, want 0 1 %h %h",
                     n, busy, cmd_ready, conn_mask, term_out, m_mask, net_in & m_mask);
         end
      end
   endtask

   initial begin
      m_mask = '1;
      test_reset();
      test_erase_single();
      test_erase_range();
      test_erase_all_connect();
      test_reject();
      test_reset_mid_sweep();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
